median_filter_bypass: RTL and testbench

MEDIAN_FILTER_BYPASS -- requirements
Module: median_filter_bypass

---
 rtl/median_filter_bypass_if.sv | 29 ++
 rtl/median_filter_bypass.sv | 146 ++++++++++++++
 tb/tb_median_filter_bypass.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_filter_bypass_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : axi4_stream_if / mf_ctrl_if
// Brief  : Pixel stream (tuser = SOF) and median-filter control interfaces.
// Rev    : 1.0
// ============================================================================

interface axi4_stream_if #(
    parameter int PX_WIDTH = 10
);
    logic [PX_WIDTH-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic                tuser;
    logic                tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

interface mf_ctrl_if;
    logic en;

    modport master (output en);
    modport slave  (input en);
endinterface

`default_nettype wire

// File: rtl/median_filter_bypass.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : median_filter_bypass
// Brief  : Frame-aligned switch between the median filter path and a bypass.
// Rev    : 1.0
// ============================================================================

module median_filter_bypass #(
    parameter int PX_WIDTH = 10,
    parameter int CNT_W    = 16
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    mf_ctrl_if.slave      mf_ctrl_i,
    axi4_stream_if.slave  video_i,
    axi4_stream_if.master mf_video_o,
    axi4_stream_if.slave  mf_video_i,
    axi4_stream_if.master video_o,
    output logic          mode_o,
    output logic          err_o
);

    localparam logic [1:0] c_FILTER = 2'd0;
    localparam logic [1:0] c_BYPASS = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]          state_q, state_d;
    logic                mode_q, mode_d;
    logic                en_req_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                w_sof_hold;
    logic                w_inc;
    logic                w_dec;
    logic [PX_WIDTH-1:0] w_vo_data;
    logic                w_vo_user;
    logic                w_vo_last;

    // An SOF beat is held back whenever the requested path differs from the active one.
    assign w_sof_hold = ((state_q == c_FILTER) || (state_q == c_BYPASS)) &&
                        (en_req_q != mode_q) && video_i.tvalid && video_i.tuser;

    assign w_inc = mf_video_o.tvalid & mf_video_o.tready;
    assign w_dec = mf_video_i.tvalid & mf_video_i.tready;

    always_comb begin
        mf_video_o.tdata  = video_i.tdata;
        mf_video_o.tuser  = video_i.tuser;
        mf_video_o.tlast  = video_i.tlast;
        mf_video_o.tvalid = 1'b0;
        video_i.tready    = 1'b0;
        mf_video_i.tready = 1'b0;
        video_o.tvalid    = 1'b0;
        w_vo_data         = mf_video_i.tdata;
        w_vo_user         = mf_video_i.tuser;
        w_vo_last         = mf_video_i.tlast;
        case (state_q)
            c_FILTER: begin
                mf_video_o.tvalid = video_i.tvalid & ~w_sof_hold;
                video_i.tready    = mf_video_o.tready & ~w_sof_hold;
                video_o.tvalid    = mf_video_i.tvalid;
                mf_video_i.tready = video_o.tready;
            end
            c_BYPASS: begin
                w_vo_data      = video_i.tdata;
                w_vo_user      = video_i.tuser;
                w_vo_last      = video_i.tlast;
                video_o.tvalid = video_i.tvalid & ~w_sof_hold;
                video_i.tready = video_o.tready & ~w_sof_hold;
            end
            c_DRAIN: begin
                if (mode_q) begin
                    video_o.tvalid    = mf_video_i.tvalid;
                    mf_video_i.tready = video_o.tready;
                end
            end
            default: ;
        endcase
        // Handshakes are cut combinationally so nothing moves while reset is asserted.
        if (!rst_i) begin
            mf_video_o.tvalid = 1'b0;
            video_i.tready    = 1'b0;
            mf_video_i.tready = 1'b0;
            video_o.tvalid    = 1'b0;
        end
    end

    assign video_o.tdata = w_vo_data;
    assign video_o.tuser = w_vo_user;
    assign video_o.tlast = w_vo_last;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            c_FILTER, c_BYPASS: begin
                if (w_sof_hold) state_d = c_DRAIN;
            end
            c_DRAIN: begin
                if (cnt_q == c_CNT_ZERO) begin
                    mode_d  = en_req_q;
                    state_d = en_req_q ? c_FILTER : c_BYPASS;
                end
            end
            default: state_d = c_FILTER;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (w_inc && !w_dec) begin
            if (&cnt_q) err_d = 1'b1;
            else        cnt_d = cnt_q + c_CNT_ONE;
        end else if (w_dec && !w_inc) begin
            if (cnt_q == c_CNT_ZERO) err_d = 1'b1;
            else                     cnt_d = cnt_q - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= c_FILTER;
            mode_q   <= 1'b1;
            en_req_q <= 1'b1;
            cnt_q    <= c_CNT_ZERO;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            en_req_q <= mf_ctrl_i.en;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign mode_o = mode_q;
    assign err_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_median_filter_bypass.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_median_filter_bypass
// Brief  : Scoreboard bench with a latency-modelled stand-in median filter (~x).
// Rev    : 1.0
// ============================================================================

module tb_median_filter_bypass;

    localparam int PXW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mode, err;

    always #5 clk = ~clk;

    mf_ctrl_if ctrl ();
    axi4_stream_if #(.PX_WIDTH(PXW)) vi ();
    axi4_stream_if #(.PX_WIDTH(PXW)) mfo ();
    axi4_stream_if #(.PX_WIDTH(PXW)) mfi ();
    axi4_stream_if #(.PX_WIDTH(PXW)) vo ();

    median_filter_bypass #(.PX_WIDTH(PXW), .CNT_W(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .mf_ctrl_i  (ctrl),
        .video_i    (vi),
        .mf_video_o (mfo),
        .mf_video_i (mfi),
        .video_o    (vo),
        .mode_o     (mode),
        .err_o      (err)
    );

    typedef struct {logic [PXW-1:0] d; logic u; logic l;} beat_t;
    typedef struct {logic [PXW-1:0] d; logic u; logic l; longint t;} fbeat_t;

    beat_t  exp_q[$];
    fbeat_t fq[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;
    bit     rnd      = 1'b0;
    int     lat      = 3;
    bit     inj_req  = 1'b0;
    bit     inj_live = 1'b0;
    logic   last_mode = 1'b1;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Stand-in filter and sinks: drive ready/valid just after each rising edge.
    initial begin
        mfi.tvalid = 1'b0; mfi.tdata = '0; mfi.tuser = 1'b0; mfi.tlast = 1'b0;
        vo.tready  = 1'b0; mfo.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            vo.tready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            mfo.tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            inj_live   = 1'b0;
            if (inj_req) begin
                mfi.tvalid = 1'b1; mfi.tdata = 10'h155; mfi.tuser = 1'b0; mfi.tlast = 1'b0;
                inj_req  = 1'b0;
                inj_live = 1'b1;
            end else if (fq.size() > 0 && fq[0].t <= cyc && (!rnd || $urandom_range(0, 1) == 1)) begin
                mfi.tvalid = 1'b1; mfi.tdata = fq[0].d; mfi.tuser = fq[0].u; mfi.tlast = fq[0].l;
            end else begin
                mfi.tvalid = 1'b0;
            end
        end
    end

    // Handshake monitor: sampled mid-cycle, where every signal is settled.
    initial forever begin
        beat_t  e;
        fbeat_t f;
        @(negedge clk);
        if (!rst_n) begin
            fq.delete();
        end else begin
            if (mfo.tvalid && mfo.tready) begin
                f.d = ~mfo.tdata; f.u = mfo.tuser; f.l = mfo.tlast; f.t = cyc + lat;
                fq.push_back(f);
            end
            if (mfi.tvalid && mfi.tready && !inj_live && fq.size() > 0) void'(fq.pop_front());
            if (vo.tvalid && vo.tready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected got=%h user=%b last=%b exp=<none>", vo.tdata, vo.tuser, vo.tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({vo.tdata, vo.tuser, vo.tlast} !== {e.d, e.u, e.l})
                        $display("FAIL sb_pixel got=%h/%b/%b exp=%h/%b/%b", vo.tdata, vo.tuser, vo.tlast, e.d, e.u, e.l);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pix(input logic [PXW-1:0] d, input logic u, input logic l,
                            input bit tog_back, output int stalls);
        bit fired;
        stalls = 0;
        if (rnd) idle($urandom_range(0, 2));
        vi.tdata = d; vi.tuser = u; vi.tlast = l; vi.tvalid = 1'b1;
        forever begin
            @(negedge clk);
            fired = vi.tready;
            @(posedge clk);
            #1;
            if (fired) break;
            stalls++;
            if (tog_back && stalls == 1) ctrl.en = 1'b1;
            if (stalls > 300) begin
                n_checks++;
                $display("FAIL send_timeout got=stalled exp=accepted data=%h", d);
                break;
            end
        end
        vi.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int fid, input logic filt, input int chg_at, input logic chg_val,
                              input bit tog_back, output int sof_stalls);
        logic [PXW-1:0] d;
        beat_t e;
        int st;
        sof_stalls = 0;
        for (int i = 0; i < 8; i++) begin
            d = PXW'(fid * 16 + i);
            if (i == chg_at) ctrl.en = chg_val;
            e.d = filt ? ~d : d; e.u = (i == 0); e.l = (i % 4 == 3);
            exp_q.push_back(e);
            send_pix(d, (i == 0), (i % 4 == 3), tog_back && (i == 0), st);
            if (i == 0) begin
                sof_stalls = st;
                if (filt != last_mode) begin
                    n_checks++;
                    if (fq.size() !== (filt ? 1 : 0))
                        $display("FAIL sof_inflight frame=%0d got=%0d exp=%0d", fid, fq.size(), filt ? 1 : 0);
                    else
                        n_pass++;
                end
            end
        end
        last_mode = filt;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() > 0 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_drain got=%0d pending exp=0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        ctrl.en = 1'b1;
        vi.tvalid = 1'b1; vi.tuser = 1'b1; vi.tlast = 1'b0; vi.tdata = '0;
        rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        n_checks++;
        if ({vi.tready, mfo.tvalid, mfi.tready, vo.tvalid} !== 4'b0000)
            $display("FAIL reset_handshake got=%b exp=0000", {vi.tready, mfo.tvalid, mfi.tready, vo.tvalid});
        else n_pass++;
        n_checks++;
        if ({mode, err} !== 2'b10) $display("FAIL reset_mode_err got=%b exp=10", {mode, err});
        else n_pass++;
        n_checks++;
        if (dut.cnt_q !== 16'd0) $display("FAIL reset_count got=%0d exp=0", dut.cnt_q);
        else n_pass++;
        @(posedge clk);
        #1;
        vi.tvalid = 1'b0;
        rst_n = 1'b1;
        last_mode = 1'b1;
        idle(2);
    endtask

    task automatic test_filter();
        int st;
        send_frame(0, 1'b1, -1, 1'b1, 1'b0, st);
        wait_drain("filter");
        idle(4);
        n_checks++;
        if (mode !== 1'b1) $display("FAIL filter_mode got=%b exp=1", mode);
        else n_pass++;
        n_checks++;
        if (dut.cnt_q !== 16'd0) $display("FAIL filter_count got=%0d exp=0", dut.cnt_q);
        else n_pass++;
    endtask

    task automatic test_switch_to_bypass();
        int st;
        send_frame(1, 1'b1, 3, 1'b0, 1'b0, st);
        send_frame(2, 1'b0, -1, 1'b0, 1'b0, st);
        n_checks++;
        if (st < 2) $display("FAIL to_bypass_sof_stall got=%0d exp=>=2", st);
        else n_pass++;
        wait_drain("to_bypass");
        n_checks++;
        if (mode !== 1'b0) $display("FAIL to_bypass_mode got=%b exp=0", mode);
        else n_pass++;
    endtask

    task automatic test_bypass_to_filter();
        int st;
        ctrl.en = 1'b1;
        idle(2);
        send_frame(3, 1'b1, -1, 1'b1, 1'b0, st);
        n_checks++;
        if (st !== 2) $display("FAIL to_filter_sof_stall got=%0d exp=2", st);
        else n_pass++;
        wait_drain("to_filter");
        n_checks++;
        if (mode !== 1'b1) $display("FAIL to_filter_mode got=%b exp=1", mode);
        else n_pass++;
    endtask

    task automatic test_toggle_back();
        int st;
        lat = 12;
        send_frame(4, 1'b1, -1, 1'b1, 1'b0, st);
        ctrl.en = 1'b0;
        idle(2);
        send_frame(5, 1'b1, -1, 1'b1, 1'b1, st);
        n_checks++;
        if (st <= 2) $display("FAIL toggle_sof_stall got=%0d exp=>2", st);
        else n_pass++;
        wait_drain("toggle");
        n_checks++;
        if (mode !== 1'b1) $display("FAIL toggle_mode got=%b exp=1", mode);
        else n_pass++;
        lat = 3;
        idle(20);
    endtask

    task automatic test_err();
        beat_t e;
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_pre got=%b exp=0", err);
        else n_pass++;
        e.d = 10'h155; e.u = 1'b0; e.l = 1'b0;
        exp_q.push_back(e);
        inj_req = 1'b1;
        idle(3);
        n_checks++;
        if (err !== 1'b1) $display("FAIL err_set got=%b exp=1", err);
        else n_pass++;
        idle(6);
        n_checks++;
        if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err);
        else n_pass++;
        wait_drain("err");
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({err, mode} !== 2'b01) $display("FAIL err_reset got=%b exp=01", {err, mode});
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_mode = 1'b1;
        idle(2);
    endtask

    task automatic test_random();
        int st;
        logic en_v;
        rnd = 1'b1;
        for (int f = 0; f < 10; f++) begin
            en_v = ($urandom_range(0, 1) == 1);
            ctrl.en = en_v;
            idle(2);
            send_frame(10 + f, en_v, -1, en_v, 1'b0, st);
        end
        wait_drain("random");
        rnd = 1'b0;
        idle(30);
        n_checks++;
        if (err !== 1'b0) $display("FAIL random_err got=%b exp=0", err);
        else n_pass++;
        n_checks++;
        if (dut.cnt_q !== 16'd0) $display("FAIL random_count got=%0d exp=0", dut.cnt_q);
        else n_pass++;
    endtask

    initial begin
        ctrl.en = 1'b1;
        vi.tvalid = 1'b0; vi.tdata = '0; vi.tuser = 1'b0; vi.tlast = 1'b0;
        test_reset();
        test_filter();
        test_switch_to_bypass();
        test_bypass_to_filter();
        test_toggle_back();
        test_err();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
